// File: rtl/mvm_uart_pkg.sv
// Shared constants, FSM state type and output-width helper for the UART
// command-driven matrix-vector multiplier.
package mvm_uart_pkg;

  localparam logic [7:0] OP_LOAD_K  = 8'h4B;
  localparam logic [7:0] OP_COMPUTE = 8'h58;
  localparam logic [7:0] RSP_Y      = 8'h59;
  localparam logic [7:0] RSP_ACK    = 8'h06;
  localparam logic [7:0] RSP_NAK    = 8'h15;

  typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK, COMPUTE, WAIT_Y, REPLY} state_t;

  // Clamp a sign-extended value to the signed w_out-bit range when sat is set;
  // otherwise pass it through so the caller keeps only the low w_out bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int w_out, input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w_out - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/axis_matvec_mul.sv
// Existing AXI-stream matrix-vector multiplier: one {K, X} beat in, one beat of
// R signed dot products out. X occupies the low bits, K row-major above it.
module axis_matvec_mul #(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8,
  localparam int W_Y = W_X + W_K + $clog2(C)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_axis_kx_tvalid,
  output logic                     s_axis_kx_tready,
  input  logic [C*W_X+R*C*W_K-1:0] s_axis_kx_tdata,
  output logic                     m_axis_y_tvalid,
  input  logic                     m_axis_y_tready,
  output logic [R*W_Y-1:0]         m_axis_y_tdata
);

  logic [R*W_Y-1:0]      y_comb;
  logic signed [W_Y-1:0] acc;
  logic signed [W_Y-1:0] kx;
  logic signed [W_Y-1:0] xx;

  assign s_axis_kx_tready = !m_axis_y_tvalid;

  always_comb begin
    y_comb = '0;
    acc    = '0;
    kx     = '0;
    xx     = '0;
    for (int r = 0; r < R; r++) begin
      acc = '0;
      for (int c = 0; c < C; c++) begin
        kx  = W_Y'($signed(s_axis_kx_tdata[C*W_X + (r*C + c)*W_K +: W_K]));
        xx  = W_Y'($signed(s_axis_kx_tdata[c*W_X +: W_X]));
        acc = acc + kx * xx;
      end
      y_comb[r*W_Y +: W_Y] = acc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_y_tvalid <= 1'b0;
      m_axis_y_tdata  <= '0;
    end else if (s_axis_kx_tvalid && s_axis_kx_tready) begin
      m_axis_y_tvalid <= 1'b1;
      m_axis_y_tdata  <= y_comb;
    end else if (m_axis_y_tready) begin
      m_axis_y_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/mvm_y_formatter.sv
// Converts one W_Y-bit signed result row into the transmitted W_Y_OUT width
// by sign-extension, saturation or truncation.
module mvm_y_formatter
  import mvm_uart_pkg::*;
#(
  parameter int W_Y      = 19,
  parameter int W_Y_OUT  = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W_Y-1:0]     y_in,
  output logic [W_Y_OUT-1:0] y_out
);

  logic signed [63:0] y_ext;
  logic signed [63:0] y_fit;

  always_comb begin
    y_ext = {{(64 - W_Y){y_in[W_Y-1]}}, y_in};
    y_fit = sat_trunc(y_ext, W_Y_OUT, (W_Y_OUT < W_Y) && SATURATE);
    y_out = W_Y_OUT'(y_fit);
  end

endmodule

// File: rtl/uart_rx.sv
// Existing UART receiver: 8N1, LSB first, one-cycle m_valid pulse per word
// issued mid stop bit.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int W_OUT            = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int BW = $clog2(W_OUT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bits;
  logic [1:0]      rx_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bits    <= '0;
      rx_sync <= 2'b11;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      m_valid <= 1'b0;
      case (state)
        RX_IDLE: if (!rx_sync[1]) begin
          cnt   <= '0;
          state <= RX_START;
        end
        RX_START: if (cnt == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
          cnt   <= '0;
          bits  <= '0;
          state <= rx_sync[1] ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
          cnt    <= '0;
          m_data <= {rx_sync[1], m_data[W_OUT-1:1]};
          bits   <= bits + 1'b1;
          if (bits == BW'(W_OUT - 1)) state <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        RX_STOP: if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
          m_valid <= 1'b1;
          state   <= RX_IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Existing UART transmitter: 8N1, LSB first, valid/ready input, tx idles high
// and is forced high by reset even mid-word.
module uart_tx #(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int W_OUT            = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [W_OUT-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             tx
);

  localparam int CW    = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int NBITS = W_OUT + 2;
  localparam int BW    = $clog2(NBITS);

  logic             busy_q;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [W_OUT:0]   frame;

  assign s_ready = !busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '1;
      tx      <= 1'b1;
    end else if (!busy_q) begin
      if (s_valid) begin
        busy_q  <= 1'b1;
        frame   <= {1'b1, s_data};
        tx      <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
      cnt <= '0;
      if (bit_idx == BW'(NBITS - 1)) begin
        busy_q <= 1'b0;
        tx     <= 1'b1;
      end else begin
        tx      <= frame[0];
        frame   <= {1'b1, frame[W_OUT:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end else cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mvm_uart_cmd_system.sv
// UART command front end for the matrix-vector multiplier: checksummed load-K and
// compute frames in, ACK/NAK or formatted y rows out.
module mvm_uart_cmd_system
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int R                = 8,
  parameter int C                = 8,
  parameter int W_X              = 8,
  parameter int W_K              = 8,
  parameter int W_Y_OUT          = 32,
  parameter bit SATURATE         = 1'b1,
  parameter int TIMEOUT_CYCLES   = 16 * CLOCKS_PER_PULSE * 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx,
  output logic busy,
  output logic k_valid,
  output logic err
);

  localparam int W_Y   = W_X + W_K + $clog2(C);
  localparam int NB    = W_Y_OUT / 8;
  localparam int N_K   = R * C;
  localparam int CNT_W = $clog2(N_K + 1);
  localparam int IDX_W = (N_K > 1) ? $clog2(N_K) : 1;
  localparam int RPL_W = $clog2(R * NB + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [BITS_PER_WORD-1:0]   rx_data;
  logic                       rx_valid;
  logic [7:0]                 tx_data;
  logic                       tx_valid, tx_ready;
  logic                       kx_valid, kx_ready, y_valid, y_ready;
  logic [C*W_X+N_K*W_K-1:0]   kx_data;
  logic [R*W_Y-1:0]           y_data;
  logic [R*W_Y_OUT-1:0]       y_fmt, y_reg;

  state_t           state;
  logic             is_load, chk_ok;
  logic [CNT_W-1:0] byte_cnt, payload_len;
  logic [7:0]       xor_acc, reply_xor, next_byte;
  logic [RPL_W-1:0] reply_idx, reply_last;
  logic [TMO_W-1:0] idle_cnt;
  logic [7:0]       staging  [N_K];
  logic [7:0]       k_shadow [N_K];

  uart_rx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .W_OUT(BITS_PER_WORD)) u_rx (
    .clk(clk), .rstn(rstn), .rx(rx), .m_data(rx_data), .m_valid(rx_valid));

  uart_tx #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE), .W_OUT(BITS_PER_WORD)) u_tx (
    .clk(clk), .rstn(rstn), .s_data(tx_data), .s_valid(tx_valid),
    .s_ready(tx_ready), .tx(tx));

  axis_matvec_mul #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) u_mvm (
    .clk(clk), .rstn(rstn),
    .s_axis_kx_tvalid(kx_valid), .s_axis_kx_tready(kx_ready), .s_axis_kx_tdata(kx_data),
    .m_axis_y_tvalid(y_valid), .m_axis_y_tready(y_ready), .m_axis_y_tdata(y_data));

  for (genvar i = 0; i < N_K; i++) begin : g_kpack
    assign kx_data[C*W_X + i*W_K +: W_K] = k_shadow[i][W_K-1:0];
  end
  for (genvar c = 0; c < C; c++) begin : g_xpack
    assign kx_data[c*W_X +: W_X] = staging[c][W_X-1:0];
  end
  for (genvar r = 0; r < R; r++) begin : g_fmt
    mvm_y_formatter #(.W_Y(W_Y), .W_Y_OUT(W_Y_OUT), .SATURATE(SATURATE)) u_fmt (
      .y_in(y_data[r*W_Y +: W_Y]), .y_out(y_fmt[r*W_Y_OUT +: W_Y_OUT]));
  end

  assign busy        = (state != IDLE);
  assign payload_len = is_load ? CNT_W'(N_K) : CNT_W'(C);

  // Byte after the one on the wire: y bytes little-endian row by row, then the running XOR.
  always_comb begin
    next_byte = reply_xor ^ tx_data;
    if (reply_idx + 1'b1 != reply_last) next_byte = y_reg[8*reply_idx +: 8];
  end

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_valid && byte_cnt != payload_len)
      staging[IDX_W'(byte_cnt)] <= rx_data;
    if (state == CHECK && chk_ok && is_load)
      k_shadow <= staging;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      is_load    <= 1'b0;
      chk_ok     <= 1'b0;
      byte_cnt   <= '0;
      xor_acc    <= '0;
      reply_xor  <= '0;
      reply_idx  <= '0;
      reply_last <= '0;
      idle_cnt   <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      kx_valid   <= 1'b0;
      y_ready    <= 1'b0;
      y_reg      <= '0;
      k_valid    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err     <= 1'b0;
      y_ready <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          if (rx_data == OP_LOAD_K || rx_data == OP_COMPUTE) begin
            is_load  <= (rx_data == OP_LOAD_K);
            byte_cnt <= '0;
            xor_acc  <= rx_data;
            idle_cnt <= '0;
            state    <= PAYLOAD;
          end else begin
            err <= 1'b1; tx_data <= RSP_NAK; tx_valid <= 1'b1;
            reply_idx <= '0; reply_last <= '0; state <= REPLY;
          end
        end
        // A byte arriving on the timeout cycle takes priority over the timeout.
        PAYLOAD: if (rx_valid) begin
          idle_cnt <= '0;
          if (byte_cnt == payload_len) begin
            chk_ok <= (xor_acc == rx_data);
            state  <= CHECK;
          end else begin
            xor_acc  <= xor_acc ^ rx_data;
            byte_cnt <= byte_cnt + 1'b1;
          end
        end else if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err <= 1'b1; tx_data <= RSP_NAK; tx_valid <= 1'b1;
          reply_idx <= '0; reply_last <= '0; state <= REPLY;
        end else idle_cnt <= idle_cnt + 1'b1;
        CHECK: if (!chk_ok || (!is_load && !k_valid)) begin
          err <= 1'b1; tx_data <= RSP_NAK; tx_valid <= 1'b1;
          reply_idx <= '0; reply_last <= '0; state <= REPLY;
        end else if (is_load) begin
          k_valid <= 1'b1; tx_data <= RSP_ACK; tx_valid <= 1'b1;
          reply_idx <= '0; reply_last <= '0; state <= REPLY;
        end else begin
          kx_valid <= 1'b1;
          state    <= COMPUTE;
        end
        COMPUTE: if (kx_ready) begin
          kx_valid <= 1'b0;
          state    <= WAIT_Y;
        end
        WAIT_Y: if (y_valid) begin
          y_reg      <= y_fmt;
          y_ready    <= 1'b1;
          tx_data    <= RSP_Y;
          tx_valid   <= 1'b1;
          reply_idx  <= '0;
          reply_last <= RPL_W'(R * NB + 1);
          reply_xor  <= '0;
          state      <= REPLY;
        end
        REPLY: if (tx_ready) begin
          reply_xor <= reply_xor ^ tx_data;
          if (reply_idx == reply_last) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_data   <= next_byte;
            reply_idx <= reply_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (rx_valid && (state inside {CHECK, COMPUTE, WAIT_Y, REPLY})) err <= 1'b1;
    end
  end

endmodule
